// File: rtl/cache_line_sequencer.sv
// Line-transfer engine: refills or writes back a 4-word cache line over a req/ack memory port.
// Optional CACHE_SEQ_CRITICAL_WORD_FIRST_EN: refills start at start_offset and wrap.
module cache_line_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCKS_NUM = 8,
  localparam int unsigned IDX_W = $clog2(BLOCKS_NUM),
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2,
  localparam int unsigned CWI_W = $clog2(4 * BLOCKS_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_write,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [IDX_W-1:0]      line_index,
  input  logic [1:0]            start_offset,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CWI_W-1:0]      cache_word_index,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       offset_q, offset_d;
  logic [1:0]       beat_q, beat_d;
  logic [1:0]       init_offset_c;

`ifdef CACHE_SEQ_CRITICAL_WORD_FIRST_EN
  // Writebacks always stream the line from word 0.
  assign init_offset_c = is_write ? 2'd0 : start_offset;
`else
  logic unused_start_offset;
  assign unused_start_offset = ^start_offset;
  assign init_offset_c       = 2'd0;
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    tag_d      = tag_q;
    index_d    = index_q;
    offset_d   = offset_q;
    beat_d     = beat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_XFER;
          is_write_d = is_write;
          tag_d      = line_tag;
          index_d    = line_index;
          offset_d   = init_offset_c;
          beat_d     = 2'd0;
        end
      end
      S_XFER: begin
        if (mem_ack) begin
          offset_d = offset_q + 2'd1;
          beat_d   = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured line fields and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      tag_q      <= '0;
      index_q    <= '0;
      offset_q   <= 2'd0;
      beat_q     <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
      offset_q   <= offset_d;
      beat_q     <= beat_d;
      busy       <= (state_d == S_XFER);
      done       <= (state_d == S_DONE);
      mem_req    <= (state_d == S_XFER);
      mem_we     <= (state_d == S_XFER) && is_write_d;
    end
  end

  // Addresses come straight from captured registers, so they hold while ack is pending.
  assign mem_addr         = ADDR_WIDTH'({tag_q, index_q, offset_q});
  assign cache_word_index = CWI_W'({index_q, offset_q});

  assign cache_we    = (state_q == S_XFER) && mem_ack && !is_write_q;
  assign cache_wdata = mem_rdata;
  assign mem_wdata   = ((state_q == S_XFER) && is_write_q) ? cache_rdata : '0;

endmodule
